// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_RTYPEEX,
        S_RTYPEWB,
        S_BEQEX,
        S_ADDIEX,
        S_ADDIWB,
        S_JEX
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // ALUOP_NONE lets idle states drive alu_control to 000.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU operation decoder: fixed ADD/SUB or R-type funct decode with illegal-funct detect.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  alu_op_t     alu_op,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_control,
    output logic        funct_illegal
);

    always_comb begin
        alu_control   = ALU_AND;
        funct_illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD:  alu_control = ALU_ADD;
            ALUOP_SUB:  alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD: alu_control = ALU_ADD;
                    FN_SUB: alu_control = ALU_SUB;
                    FN_AND: alu_control = ALU_AND;
                    FN_OR:  alu_control = ALU_OR;
                    FN_SLT: alu_control = ALU_SLT;
                    default: begin
                        alu_control   = ALU_ADD;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default:    alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath, with sticky illegal-op flag
// and retired-instruction counter.
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    output logic                 pc_en,
    output logic                 i_or_d,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           pc_src,
    output logic [2:0]           alu_control,
    output logic                 illegal_op,
    output logic [CNT_WIDTH-1:0] instr_count
);

    state_t                 state_q, state_d;
    logic                   illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;

    alu_op_t                alu_op;
    logic                   funct_illegal;
    logic                   pc_write;
    logic                   branch;
    logic                   ir_write_s;
    logic                   mem_write_s;
    logic                   reg_write_s;

    alu_decoder u_alu_dec (
        .alu_op        (alu_op),
        .funct         (funct),
        .alu_control   (alu_control),
        .funct_illegal (funct_illegal)
    );

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        count_d   = count_q;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: begin
                state_d = S_RTYPEWB;
                if (funct_illegal) illegal_d = 1'b1;
            end
            S_ADDIEX:  state_d = S_ADDIWB;
            S_MEMWB, S_MEMWR, S_RTYPEWB, S_BEQEX, S_ADDIWB, S_JEX: begin
                state_d = S_FETCH;
                count_d = count_q + CNT_WIDTH'(1);
            end
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        pc_write    = 1'b0;
        branch      = 1'b0;
        i_or_d      = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write_s = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        pc_src      = PCSRC_ALU;
        alu_op      = ALUOP_NONE;
        case (state_q)
            S_FETCH: begin
                ir_write_s = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                alu_op     = ALUOP_ADD;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            S_MEMRD:   i_or_d = 1'b1;
            S_MEMWB: begin
                reg_write_s = 1'b1;
                mem_to_reg  = 1'b1;
            end
            S_MEMWR: begin
                i_or_d      = 1'b1;
                mem_write_s = 1'b1;
            end
            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                reg_dst     = 1'b1;
                reg_write_s = 1'b1;
            end
            S_BEQEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
            end
            S_ADDIWB:  reg_write_s = 1'b1;
            S_JEX: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset parks the FSM in FETCH, so the write strobes must be masked by rst_n directly.
    assign ir_write    = ir_write_s & rst_n;
    assign mem_write   = mem_write_s & rst_n;
    assign reg_write   = reg_write_s & rst_n;
    assign pc_en       = (pc_write | (branch & zero)) & rst_n;
    assign illegal_op  = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: instruction-level reference model pushes per-cycle control words,
// a negedge monitor pops and compares against the DUT.
module tb_multicycle_controller;

    localparam int CW = 4;

    localparam logic [5:0] T_RTYPE = 6'b000000;
    localparam logic [5:0] T_LW    = 6'b100011;
    localparam logic [5:0] T_SW    = 6'b101011;
    localparam logic [5:0] T_BEQ   = 6'b000100;
    localparam logic [5:0] T_ADDI  = 6'b001000;
    localparam logic [5:0] T_J     = 6'b000010;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    op = '0;
    logic [5:0]    funct = '0;
    logic          zero = 1'b0;
    logic          pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg;
    logic          reg_write, alu_src_a, illegal_op;
    logic [1:0]    alu_src_b, pc_src;
    logic [2:0]    alu_control;
    logic [CW-1:0] instr_count;

    multicycle_controller #(.CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .pc_en       (pc_en),
        .i_or_d      (i_or_d),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          pc_en;
        logic          i_or_d;
        logic          mem_write;
        logic          ir_write;
        logic          reg_dst;
        logic          mem_to_reg;
        logic          reg_write;
        logic          alu_src_a;
        logic [1:0]    alu_src_b;
        logic [1:0]    pc_src;
        logic [2:0]    alu_control;
        logic          illegal_op;
        logic [CW-1:0] instr_count;
    } ctrl_t;

    ctrl_t act;
    assign act = {pc_en, i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
                  alu_src_a, alu_src_b, pc_src, alu_control, illegal_op, instr_count};

    ctrl_t  exp_q[$];
    string  tag_q[$];
    int     total = 0;
    int     bad = 0;
    bit     mon_en = 1'b0;
    int     m_count = 0;
    bit     m_illegal = 1'b0;

    ctrl_t  mon_e;
    string  mon_t;

    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL underrun: no expected word, actual=%h", act);
            end else begin
                mon_e = exp_q.pop_front();
                mon_t = tag_q.pop_front();
                if (act !== mon_e) begin
                    bad++;
                    $display("FAIL %s: actual=%h required=%h (t=%0t)", mon_t, act, mon_e, $time);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic ctrl_t base();
        ctrl_t c;
        c = '0;
        c.illegal_op  = m_illegal;
        c.instr_count = CW'(m_count);
        return c;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f, output bit illegal);
        illegal = 1'b0;
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default: begin
                illegal = 1'b1;
                return 3'b010;
            end
        endcase
    endfunction

    task automatic push(input ctrl_t c, input string tag);
        exp_q.push_back(c);
        tag_q.push_back(tag);
    endtask

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, a, e);
        end
    endtask

    task automatic push_fetch_decode(input string name);
        ctrl_t c;
        c = base();
        c.ir_write = 1'b1; c.pc_en = 1'b1; c.alu_src_b = 2'b01; c.alu_control = 3'b010;
        push(c, {name, " fetch"});
        c = base();
        c.alu_src_b = 2'b11; c.alu_control = 3'b010;
        push(c, {name, " decode"});
    endtask

    // Called at posedge+1 with the DUT in FETCH; returns at posedge+1 of the next FETCH.
    task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic z, input string name);
        ctrl_t c;
        bit    fbad;
        bit    retire;
        int    n;
        op = o; funct = f; zero = z;
        push_fetch_decode(name);
        n = 2;
        retire = 1'b1;
        case (o)
            T_LW, T_SW: begin
                c = base();
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = 3'b010;
                push(c, {name, " memadr"});
                if (o == T_LW) begin
                    c = base(); c.i_or_d = 1'b1;
                    push(c, {name, " memrd"});
                    c = base(); c.reg_write = 1'b1; c.mem_to_reg = 1'b1;
                    push(c, {name, " memwb"});
                    n += 3;
                end else begin
                    c = base(); c.i_or_d = 1'b1; c.mem_write = 1'b1;
                    push(c, {name, " memwr"});
                    n += 2;
                end
            end
            T_RTYPE: begin
                c = base();
                c.alu_src_a = 1'b1; c.alu_control = funct_alu(f, fbad);
                push(c, {name, " rtypeex"});
                if (fbad) m_illegal = 1'b1;
                c = base(); c.reg_dst = 1'b1; c.reg_write = 1'b1;
                push(c, {name, " rtypewb"});
                n += 2;
            end
            T_BEQ: begin
                c = base();
                c.alu_src_a = 1'b1; c.alu_control = 3'b110; c.pc_src = 2'b01; c.pc_en = z;
                push(c, {name, " beqex"});
                n += 1;
            end
            T_ADDI: begin
                c = base();
                c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = 3'b010;
                push(c, {name, " addiex"});
                c = base(); c.reg_write = 1'b1;
                push(c, {name, " addiwb"});
                n += 2;
            end
            T_J: begin
                c = base(); c.pc_src = 2'b10; c.pc_en = 1'b1;
                push(c, {name, " jex"});
                n += 1;
            end
            default: begin
                m_illegal = 1'b1;
                retire = 1'b0;
            end
        endcase
        if (retire) m_count = (m_count + 1) % (1 << CW);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        ctrl_t c;
        rst_n = 1'b0;
        m_count = 0;
        m_illegal = 1'b0;
        for (int i = 0; i < n; i++) begin
            c = base(); c.alu_src_b = 2'b01; c.alu_control = 3'b010;
            push(c, "reset");
        end
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic reset_during_memwr();
        ctrl_t c;
        op = T_SW; funct = '0; zero = 1'b0;
        push_fetch_decode("sw-rst");
        c = base();
        c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_control = 3'b010;
        push(c, "sw-rst memadr");
        c = base(); c.i_or_d = 1'b1; c.mem_write = 1'b1;
        push(c, "sw-rst memwr");
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst mem_write", 32'(mem_write), 32'd0);
        chk("midrst pc_en", 32'(pc_en), 32'd0);
        chk("midrst alu_src_b", 32'(alu_src_b), 32'd1);
        chk("midrst i_or_d", 32'(i_or_d), 32'd0);
        chk("midrst instr_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;
        do_reset(1);
    endtask

    logic [5:0] legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        mon_en = 1'b1;
        @(posedge clk);
        #1;
        do_reset(2);

        issue(T_LW, 6'h15, 1'b0, "lw");
        issue(T_SW, 6'h00, 1'b0, "sw");
        issue(T_RTYPE, 6'b100010, 1'b0, "sub");
        issue(T_BEQ, 6'h00, 1'b1, "beq-z1");
        issue(T_BEQ, 6'h00, 1'b0, "beq-z0");
        issue(T_ADDI, 6'h3f, 1'b1, "addi");
        issue(T_J, 6'h00, 1'b0, "j");
        issue(6'b111111, 6'h00, 1'b0, "illop");
        issue(T_LW, 6'h00, 1'b0, "lw-after-ill");
        reset_during_memwr();
        issue(T_RTYPE, 6'b000000, 1'b0, "bad-funct");
        issue(T_RTYPE, 6'b100101, 1'b0, "or");

        do_reset(1);
        for (int i = 0; i < 16; i++) issue(T_RTYPE, 6'b100000, 1'b0, "wrap-add");
        chk("wrap instr_count", 32'(instr_count), 32'd0);

        for (int i = 0; i < 300; i++) begin
            int k;
            logic [5:0] rf;
            logic       rz;
            k  = $urandom_range(0, 10);
            rf = 6'($urandom);
            rz = 1'($urandom);
            case (k)
                0:  issue(T_LW, rf, rz, "r-lw");
                1:  issue(T_SW, rf, rz, "r-sw");
                2, 3: issue(T_RTYPE, legal_fn[$urandom_range(0, 4)], rz, "r-rtype");
                4:  issue(T_RTYPE, rf, rz, "r-rtype-any");
                5:  issue(T_BEQ, rf, rz, "r-beq");
                6:  issue(T_ADDI, rf, rz, "r-addi");
                7:  issue(T_J, rf, rz, "r-j");
                8:  issue(6'($urandom), rf, rz, "r-anyop");
                9:  begin
                        if ($urandom_range(0, 3) == 0) do_reset(1 + $urandom_range(0, 1));
                        else issue(T_LW, rf, rz, "r-lw2");
                    end
                default: issue(T_BEQ, rf, 1'b1, "r-beq-taken");
            endcase
        end

        mon_en = 1'b0;
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
